dualportram_be: RTL and testbench

DUALPORTRAM_BE -- requirements
Module: dualportram_be

---
 rtl/dualportram_be.sv | 119 +++++++++++
 tb/tb_dualportram_be.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dualportram_be.sv
// dualportram_be: true dual-port RAM with byte enables, zeroing sweep after reset,
// configurable read latency, read-during-write behaviour and collision priority.
module dualportram_be #(
   parameter int DEPTH      = 10,
   parameter int WIDTH      = 32,
   parameter int WORDS      = 1024,
   parameter int RD_LATENCY = 1,
   parameter int RDW_MODE   = 0,
   parameter int PRIORITY_B = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               we,
   input  logic               oe,
   input  logic [WIDTH/8-1:0] be,
   input  logic [DEPTH-1:0]   address,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout,
   output logic               dout_valid,
   input  logic               we_b,
   input  logic               oe_b,
   input  logic [WIDTH/8-1:0] be_b,
   input  logic [DEPTH-1:0]   address_b,
   input  logic [WIDTH-1:0]   din_b,
   output logic [WIDTH-1:0]   dout_b,
   output logic               dout_b_valid,
   output logic               busy,
   output logic               collision,
   output logic [31:0]        length
);
   localparam int NB = WIDTH / 8;
   localparam logic [DEPTH-1:0] LAST = DEPTH'(WORDS - 1);
   typedef enum logic {INIT, READY} state_t;
   state_t r_state, w_next;
   logic [DEPTH-1:0] r_sweep;
   logic [WIDTH-1:0] r_mem [WORDS];
   logic             w_rdy, w_in_a, w_in_b, w_we_a, w_we_b, w_re_a, w_re_b, w_coll;
   logic [WIDTH-1:0] w_old_a, w_old_b, w_mrg_a, w_mrg_b, w_rd_a, w_rd_b;
   logic [WIDTH-1:0] r_d1_a, r_d1_b, w_od_a, w_od_b;
   logic             r_v1_a, r_v1_b, w_ov_a, w_ov_b;
   logic             w_we_w, w_we_l;
   logic [DEPTH-1:0] w_ad_w, w_ad_l;
   logic [NB-1:0]    w_be_w, w_be_l;
   logic [WIDTH-1:0] w_din_w, w_din_l;
   assign length  = 32'(WORDS);
   assign w_rdy   = r_state == READY;
   assign busy    = !w_rdy;
   assign w_in_a  = int'(address) < WORDS;
   assign w_in_b  = int'(address_b) < WORDS;
   assign w_we_a  = w_rdy && we && w_in_a;
   assign w_we_b  = w_rdy && we_b && w_in_b;
   assign w_re_a  = w_rdy && oe;
   assign w_re_b  = w_rdy && oe_b;
   assign w_coll  = w_we_a && w_we_b && address == address_b;
   assign w_old_a = w_in_a ? r_mem[address] : '0;
   assign w_old_b = w_in_b ? r_mem[address_b] : '0;
   always_comb begin
      w_mrg_a = w_old_a;
      w_mrg_b = w_old_b;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) w_mrg_a[8*i +: 8] = din[8*i +: 8];
         if (be_b[i]) w_mrg_b[8*i +: 8] = din_b[8*i +: 8];
      end
   end
   // Cross-port reads always see the array before this edge's writes.
   assign w_rd_a = (RDW_MODE != 0 && w_we_a) ? w_mrg_a : w_old_a;
   assign w_rd_b = (RDW_MODE != 0 && w_we_b) ? w_mrg_b : w_old_b;
   assign w_we_w  = PRIORITY_B != 0 ? w_we_b    : w_we_a;
   assign w_ad_w  = PRIORITY_B != 0 ? address_b : address;
   assign w_be_w  = PRIORITY_B != 0 ? be_b      : be;
   assign w_din_w = PRIORITY_B != 0 ? din_b     : din;
   assign w_we_l  = PRIORITY_B != 0 ? w_we_a    : w_we_b;
   assign w_ad_l  = PRIORITY_B != 0 ? address   : address_b;
   assign w_be_l  = PRIORITY_B != 0 ? be        : be_b;
   assign w_din_l = PRIORITY_B != 0 ? din       : din_b;
   // Loser bytes are scheduled first so the winner's enabled bytes override them.
   always_ff @(posedge clk) begin
      if (!w_rdy && reset) r_mem[r_sweep] <= '0;
      for (int i = 0; i < NB; i++) begin
         if (w_we_l && w_be_l[i]) r_mem[w_ad_l][8*i +: 8] <= w_din_l[8*i +: 8];
         if (w_we_w && w_be_w[i]) r_mem[w_ad_w][8*i +: 8] <= w_din_w[8*i +: 8];
      end
   end
   always_comb begin
      w_next = r_state;
      if (r_state == INIT && r_sweep == LAST) w_next = READY;
   end
   assign w_ov_a = RD_LATENCY == 1 ? w_re_a : r_v1_a;
   assign w_ov_b = RD_LATENCY == 1 ? w_re_b : r_v1_b;
   assign w_od_a = RD_LATENCY == 1 ? w_rd_a : r_d1_a;
   assign w_od_b = RD_LATENCY == 1 ? w_rd_b : r_d1_b;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= INIT;
         r_sweep      <= '0;
         r_v1_a       <= 1'b0;
         r_v1_b       <= 1'b0;
         r_d1_a       <= '0;
         r_d1_b       <= '0;
         dout         <= '0;
         dout_b       <= '0;
         dout_valid   <= 1'b0;
         dout_b_valid <= 1'b0;
         collision    <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_sweep      <= w_rdy ? r_sweep : r_sweep + 1'b1;
         collision    <= w_coll;
         r_v1_a       <= w_re_a;
         r_v1_b       <= w_re_b;
         if (w_re_a) r_d1_a <= w_rd_a;
         if (w_re_b) r_d1_b <= w_rd_b;
         dout_valid   <= w_ov_a;
         dout_b_valid <= w_ov_b;
         if (w_ov_a) dout <= w_od_a;
         if (w_ov_b) dout_b <= w_od_b;
      end
   end
endmodule

// File: tb/tb_dualportram_be.sv
// tb_dualportram_be: scoreboard bench; expected read data is queued at issue time
// and popped by a monitor whenever a valid strobe appears.
module tb_dualportram_be;
   localparam int DEPTH = 8;
   localparam int WORDS = 200;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        we = 0, oe = 0, we_b = 0, oe_b = 0;
   logic [3:0]  be = 0, be_b = 0;
   logic [7:0]  address = 0, address_b = 0;
   logic [31:0] din = 0, din_b = 0;
   logic [31:0] dout, dout_b, length;
   logic        dout_valid, dout_b_valid, busy, collision;
   logic [31:0] qa[$], qb[$];
   int          total = 0, bad = 0;
   dualportram_be #(.DEPTH(DEPTH), .WIDTH(32), .WORDS(WORDS), .RD_LATENCY(2),
                    .RDW_MODE(0), .PRIORITY_B(0)) dut (
      .clk(clk), .reset(reset),
      .we(we), .oe(oe), .be(be), .address(address), .din(din),
      .dout(dout), .dout_valid(dout_valid),
      .we_b(we_b), .oe_b(oe_b), .be_b(be_b), .address_b(address_b), .din_b(din_b),
      .dout_b(dout_b), .dout_b_valid(dout_b_valid),
      .busy(busy), .collision(collision), .length(length));
   always #5 clk = ~clk;
   always @(negedge clk) begin
      if (dout_valid) begin
         total++;
         if (qa.size() == 0) begin
            bad++;
            $display("FAIL rd_a unexpected strobe act=%h", dout);
         end else begin
            logic [31:0] e;
            e = qa.pop_front();
            if (dout !== e) begin
               bad++;
               $display("FAIL rd_a act=%h exp=%h", dout, e);
            end
         end
      end
      if (dout_b_valid) begin
         total++;
         if (qb.size() == 0) begin
            bad++;
            $display("FAIL rd_b unexpected strobe act=%h", dout_b);
         end else begin
            logic [31:0] e;
            e = qb.pop_front();
            if (dout_b !== e) begin
               bad++;
               $display("FAIL rd_b act=%h exp=%h", dout_b, e);
            end
         end
      end
   end
   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", n, a, e);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic wr_a(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
      we = 1; address = a; din = d; be = m;
      step();
      we = 0;
   endtask
   task automatic wr_b(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m);
      we_b = 1; address_b = a; din_b = d; be_b = m;
      step();
      we_b = 0;
   endtask
   task automatic rd_a(input logic [7:0] a, input logic [31:0] e);
      oe = 1; address = a; qa.push_back(e);
      step();
      oe = 0;
   endtask
   task automatic rd_b(input logic [7:0] a, input logic [31:0] e);
      oe_b = 1; address_b = a; qb.push_back(e);
      step();
      oe_b = 0;
   endtask
   task automatic count_busy(input string n);
      int c = 0;
      while (c < 1000) begin
         step();
         c++;
         if (c == 50) begin
            we = 0; oe = 0; oe_b = 0;
         end
         if (!busy) break;
      end
      chk(n, 32'(c), 32'(WORDS));
   endtask
   initial begin
      repeat (3) step();
      chk("rst_busy", 32'(busy), 1);
      chk("rst_valid", {30'b0, dout_valid, dout_b_valid}, 0);
      chk("rst_coll", 32'(collision), 0);
      chk("rst_length", length, 32'(WORDS));
      chk("rst_dout", dout, 0);
      // user traffic during the sweep must be ignored
      we = 1; oe = 1; oe_b = 1; address = 5; address_b = 5; din = 32'hFFFF_FFFF; be = 4'hF;
      reset = 1;
      count_busy("init_busy_cycles");
      rd_a(0, 0);
      rd_a(5, 0);
      rd_a(8'(WORDS - 1), 0);
      wr_a(3, 32'hAABB_CCDD, 4'hF);
      wr_a(3, 32'h1122_3344, 4'b0101);
      rd_a(3, 32'hAA22_CC44);
      we = 1; address = 7; din = 32'h1111_1111; be = 4'b0011;
      we_b = 1; address_b = 7; din_b = 32'h2222_2222; be_b = 4'hF;
      step();
      we = 0; we_b = 0;
      chk("coll_pulse", 32'(collision), 1);
      step();
      chk("coll_once", 32'(collision), 0);
      rd_b(7, 32'h2222_1111);
      we = 1; address = 20; din = 1; be = 4'hF;
      we_b = 1; address_b = 21; din_b = 2; be_b = 4'hF;
      step();
      we = 0; we_b = 0;
      chk("no_coll_diff_addr", 32'(collision), 0);
      rd_a(20, 1);
      rd_b(21, 2);
      wr_a(9, 5, 4'hF);
      we = 1; oe = 1; address = 9; din = 6; be = 4'hF;
      oe_b = 1; address_b = 9;
      qa.push_back(5); qb.push_back(5);
      step();
      we = 0; oe = 0; oe_b = 0;
      rd_a(9, 6);
      wr_a(250, 32'hFFFF_FFFF, 4'hF);
      rd_a(250, 0);
      we = 1; address = 250; din = 3; be = 4'hF;
      we_b = 1; address_b = 250; din_b = 4; be_b = 4'hF;
      step();
      we = 0; we_b = 0;
      chk("no_coll_oor", 32'(collision), 0);
      wr_b(8'(WORDS - 1), 32'hCAFE_BABE, 4'hF);
      rd_a(8'(WORDS - 1), 32'hCAFE_BABE);
      wr_a(0, 32'h10, 4'hF);
      wr_a(1, 32'h21, 4'hF);
      wr_a(2, 32'h32, 4'hF);
      wr_a(3, 32'h43, 4'hF);
      repeat (4) step();
      fork
         begin
            for (int i = 0; i < 4; i++) rd_a(8'(i), 32'h10 + 32'(i) * 32'h11);
         end
         begin
            int k = 0;
            int run = 0;
            while (k < 12 && !dout_valid) begin
               @(negedge clk);
               k++;
            end
            while (dout_valid && run < 8) begin
               run++;
               @(negedge clk);
            end
            chk("pipe_run", 32'(run), 4);
         end
      join
      repeat (4) step();
      chk("dout_hold", dout, 32'h43);
      chk("dout_hold_valid", 32'(dout_valid), 0);
      oe = 1; address = 0;
      step();
      oe = 0; reset = 0;
      #1;
      chk("abort_valid", 32'(dout_valid), 0);
      chk("abort_dout", dout, 0);
      chk("abort_busy", 32'(busy), 1);
      repeat (2) step();
      reset = 1;
      repeat (100) step();
      chk("midsweep_busy", 32'(busy), 1);
      reset = 0;
      repeat (2) step();
      chk("midsweep_rst_busy", 32'(busy), 1);
      reset = 1;
      count_busy("resweep_busy_cycles");
      rd_a(9, 0);
      rd_a(8'(WORDS - 1), 0);
      rd_b(7, 0);
      repeat (6) step();
      chk("qa_drained", 32'(qa.size()), 0);
      chk("qb_drained", 32'(qb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
